detector_debounce: RTL
======================

Name: detector_debounce

Overview:
- Conditions the raw 4-bit obstacle detector vector from the simulator link before it reaches the auto-driving FSM and the semi-auto controller.
- Stage 1: two-flop synchroniser per bit. Stage 2: per-bit consecutive-sample debounce counter, so single-sample glitches never trigger a turn decision.
- Provides a one-cycle change strobe and a settled flag. The auto FSM can use these to gate MAKING_DESICION on a stable view of the surroundings.

Parameters:
- WIDTH, 4: number of detector bits.
- STABLE_CNT, 10: consecutive mismatching samples needed before an output bit flips; legal range 1 to 2^CNT_W-1.
- CNT_W, 8: width of each per-bit counter.
- INIT_VALUE, 4'b0000: value loaded into detector on reset.

Ports:
- clk  input  1  system tick clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  debounce enable; low freezes detector outputs.
- raw_detector  input  WIDTH  unsynchronised detector bits from the link receiver.
- detector  output  WIDTH  debounced detector vector (registered).
- changed  output  1  one-cycle pulse when any detector bit flipped at the previous edge (registered).
- settled  output  1  high when no bit has a pending change.

Behaviour:
- Reset (rst=1 at posedge): sync1 = 0, sync2 = 0, all cnt[i] = 0, detector = INIT_VALUE, changed = 0. Reset has priority over enable and over any in-progress count; a partially counted mismatch is discarded.
- Synchroniser: every posedge (enable ignored), sync1 <= raw_detector and sync2 <= sync1.
- Per bit i, each posedge with enable=1:
  - If sync2[i] == detector[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CNT-1: detector[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: raw change sampled at edge k -> sync2 valid after edge k+1 -> detector updates at edge k+1+STABLE_CNT, provided the raw value is held the whole time.
- Glitch rejection: a mismatch lasting fewer than STABLE_CNT sync2 samples leaves detector unchanged, and its counter returns to 0 on the first matching sample.
- Bits are independent. Several bits may flip at the same edge.
- changed <= 1 at any edge where at least one detector bit flips, otherwise 0. Simultaneous flips produce a single one-cycle pulse.
- Back-to-back flips on consecutive edges (different bits) hold changed high for consecutive cycles.
- settled = (sync2 == detector) AND all cnt == 0. This is combinational from registers. It is low during any pending mismatch, including the cycle in which the counter is still 0.
- enable=0 at posedge:
  - cnt[i] <= 0 and changed <= 0.
  - detector holds its value.
  - The synchroniser keeps running.
  - On re-enable, counting restarts from 0.
- STABLE_CNT=1: a bit flips on the first edge at which the mismatch is observed, i.e. at edge k+2 for a raw change sampled at k.
- Counters never exceed STABLE_CNT-1; no wrap-around is possible for legal parameters.
- Downstream consumers sample on negedge. Outputs change only on posedge, so they are stable for the full half-cycle.

Test Plan:
1. Reset with rst=1 for 2 cycles, raw=4'b1011 -> detector=4'b0000, changed=0, settled=0 (sync2 mismatch) once rst is released.
2. STABLE_CNT=10, enable=1, raw steps 0000->0001 and is held -> detector becomes 0001 exactly 11 cycles after the raw sample edge. changed is high for exactly that one cycle. settled rises in the same cycle.
3. Glitch: raw bit2 high for 9 sync2 samples, then low -> detector stays 0000, changed never pulses, cnt[2] returns to 0, settled returns high.
4. Simultaneous flip: raw 0000->1101 in one cycle -> all three bits flip at the same edge, detector=1101, single one-cycle changed pulse.
5. enable dropped after 5 mismatch samples and re-raised 3 cycles later with raw held -> detector flips 10 cycles after re-enable, not earlier. changed=0 throughout the disabled period.
6. rst asserted mid-count (cnt=7) -> the next cycle shows cnt=0 and detector=INIT_VALUE. With raw still held, the flip occurs 11 cycles after rst is released.

Source files
------------

// File: rtl/detector_debounce.sv
// detector_debounce: two-flop synchroniser plus per-bit consecutive-sample debounce with a change strobe and a settled flag; in: clk, rst, enable, raw_detector; out: detector, changed, settled
module detector_debounce #(
  parameter int               WIDTH      = 4,
  parameter int               STABLE_CNT = 10,
  parameter int               CNT_W      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] raw_detector,
  output logic [WIDTH-1:0] detector,
  output logic             changed,
  output logic             settled
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
  logic [WIDTH-1:0] sync1, sync2, flip, cnt_busy;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      flip[i]     = enable && (sync2[i] != detector[i]) && (cnt[i] == LAST);
      cnt_next[i] = (!enable || sync2[i] == detector[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
      cnt_busy[i] = |cnt[i];
    end
  end
  assign settled = (sync2 == detector) && !(|cnt_busy);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      detector <= INIT_VALUE;
      changed  <= 1'b0;
      cnt      <= '{default: '0};
    end else begin
      sync1    <= raw_detector;
      sync2    <= sync1;
      detector <= detector ^ flip;
      changed  <= |flip;
      cnt      <= cnt_next;
    end
  end
endmodule
